// File: rtl/inst_fetch.sv
// Instruction fetch: PC consumer, req/gnt/rvalid memory master, IF/ID output regs.
// Optional IFETCH_BUS_ERR_EN adds i_mem_err / o_inst_err bus-error reporting.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_jump_flag,
    input  logic              i_stall,
    output logic              o_hold_req,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef IFETCH_BUS_ERR_EN
    input  logic              i_mem_err,
    output logic              o_inst_err,
`endif
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_addr,
    output logic              o_inst_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_BUF, S_DROP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_buf;
    logic              w_deliver;
    logic              w_cap;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_inst;
`ifdef IFETCH_BUS_ERR_EN
    logic              r_buf_err;
    logic              w_err;
`endif

    always_comb begin
        w_next    = r_state;
        w_deliver = 1'b0;
        w_cap     = 1'b0;
        w_data    = i_mem_rdata;
`ifdef IFETCH_BUS_ERR_EN
        w_err     = i_mem_err;
`endif
        unique case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ: begin
                if (i_mem_gnt)
                    w_next = i_jump_flag ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (i_jump_flag) begin
                    w_next = i_mem_rvalid ? S_REQ : S_DROP;
                end else if (i_mem_rvalid) begin
                    if (i_stall) begin
                        w_cap  = 1'b1;
                        w_next = S_BUF;
                    end else begin
                        w_deliver = 1'b1;
                        w_next    = S_REQ;
                    end
                end
            end
            S_BUF: begin
                w_data = r_buf;
`ifdef IFETCH_BUS_ERR_EN
                w_err  = r_buf_err;
`endif
                if (i_jump_flag) begin
                    w_next = S_REQ;
                end else if (!i_stall) begin
                    w_deliver = 1'b1;
                    w_next    = S_REQ;
                end
            end
            S_DROP: begin
                if (i_mem_rvalid)
                    w_next = S_REQ;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef IFETCH_BUS_ERR_EN
    assign w_inst = w_err ? NOP_INST : w_data;
`else
    assign w_inst = w_data;
`endif

    assign o_mem_req  = (r_state == S_REQ);
    assign o_mem_addr = i_pc;
    assign o_hold_req = !w_deliver;

    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_REQ && i_mem_gnt)
                r_addr <= i_pc;
            if (w_cap)
                r_buf <= i_mem_rdata;
        end
    end

`ifdef IFETCH_BUS_ERR_EN
    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            r_buf_err  <= 1'b0;
            o_inst_err <= 1'b0;
        end else begin
            if (w_cap)
                r_buf_err <= i_mem_err;
            if (i_jump_flag)
                o_inst_err <= 1'b0;
            else if (!i_stall)
                o_inst_err <= w_deliver & w_err;
        end
    end
`endif

    // Jump flushes even a stalled IF/ID; stall otherwise freezes everything.
    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            o_inst       <= NOP_INST;
            o_inst_addr  <= '0;
            o_inst_valid <= 1'b0;
        end else if (i_jump_flag) begin
            o_inst       <= NOP_INST;
            o_inst_valid <= 1'b0;
        end else if (!i_stall) begin
            if (w_deliver) begin
                o_inst       <= w_inst;
                o_inst_addr  <= r_addr;
                o_inst_valid <= 1'b1;
            end else begin
                o_inst       <= NOP_INST;
                o_inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch, one vector per clock cycle.
// Extra error-response sequence is compiled in with IFETCH_BUS_ERR_EN.
module tb_inst_fetch;

    localparam logic [31:0] N = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic        j;
        logic        s;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic        ereq;
        logic        ehold;
        logic [31:0] einst;
        logic [31:0] eia;
        logic        ev;
        logic        eerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        jump = 1'b0;
    logic        stall = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        merr = 1'b0;
    logic        hold;
    logic        req;
    logic [31:0] maddr;
    logic [31:0] inst;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        ierr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .i_Clk       (clk),
        .i_reset     (rst_n),
        .i_pc        (pc),
        .i_jump_flag (jump),
        .i_stall     (stall),
        .o_hold_req  (hold),
        .o_mem_req   (req),
        .o_mem_addr  (maddr),
        .i_mem_gnt   (gnt),
        .i_mem_rvalid(rvalid),
        .i_mem_rdata (rdata),
`ifdef IFETCH_BUS_ERR_EN
        .i_mem_err   (merr),
        .o_inst_err  (ierr),
`endif
        .o_inst      (inst),
        .o_inst_addr (iaddr),
        .o_inst_valid(ivalid)
    );

`ifndef IFETCH_BUS_ERR_EN
    assign ierr = 1'b0;
`endif

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] p, input logic jj, input logic ss,
        input logic gg, input logic rr, input logic [31:0] dd,
        input logic ee, input logic xreq, input logic xhold,
        input logic [31:0] xinst, input logic [31:0] xia,
        input logic xv, input logic xerr);
        vec_t t;
        t.pc = p; t.j = jj; t.s = ss; t.g = gg; t.rv = rr;
        t.rd = dd; t.er = ee; t.ereq = xreq; t.ehold = xhold;
        t.einst = xinst; t.eia = xia; t.ev = xv; t.eerr = xerr;
        return t;
    endfunction

    task automatic run(input vec_t v, input int idx);
        @(negedge clk);
        pc = v.pc; jump = v.j; stall = v.s; gnt = v.g;
        rvalid = v.rv; rdata = v.rd; merr = v.er;
        #1;
        chk("mem_req", idx, {31'd0, req}, {31'd0, v.ereq});
        chk("hold_req", idx, {31'd0, hold}, {31'd0, v.ehold});
        if (v.ereq)
            chk("mem_addr", idx, maddr, v.pc);
        @(posedge clk);
        #1;
        chk("inst", idx, inst, v.einst);
        chk("inst_addr", idx, iaddr, v.eia);
        chk("inst_valid", idx, {31'd0, ivalid}, {31'd0, v.ev});
        chk("inst_err", idx, {31'd0, ierr}, {31'd0, v.eerr});
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_inst", idx, inst, N);
        chk("rst_iaddr", idx, iaddr, 32'h0);
        chk("rst_valid", idx, {31'd0, ivalid}, 32'd0);
        chk("rst_req", idx, {31'd0, req}, 32'd0);
        chk("rst_hold", idx, {31'd0, hold}, 32'd1);
        chk("rst_err", idx, {31'd0, ierr}, 32'd0);
    endtask

    vec_t tab[$];
    vec_t seq[$];

    initial begin
        // fetch 0x0, then gnt held off three cycles at 0x4
        tab.push_back(mk(0,0,0,0,0,0,0, 0,1,N,0,0,0));
        tab.push_back(mk(0,0,0,1,0,0,0, 1,1,N,0,0,0));
        tab.push_back(mk(0,0,0,0,1,32'h00500093,0,
                         0,0,32'h00500093,0,1,0));
        tab.push_back(mk(4,0,0,0,0,0,0, 1,1,N,0,0,0));
        tab.push_back(mk(4,0,0,0,0,0,0, 1,1,N,0,0,0));
        tab.push_back(mk(4,0,0,0,0,0,0, 1,1,N,0,0,0));
        tab.push_back(mk(4,0,0,1,0,0,0, 1,1,N,0,0,0));
        tab.push_back(mk(4,0,0,0,1,32'h00100113,0,
                         0,0,32'h00100113,4,1,0));
        // stall on response -> BUF, release delivers
        tab.push_back(mk(8,0,0,1,0,0,0, 1,1,N,4,0,0));
        tab.push_back(mk(8,0,1,0,1,32'h00A00113,0, 0,1,N,4,0,0));
        tab.push_back(mk(8,0,1,0,0,0,0, 0,1,N,4,0,0));
        tab.push_back(mk(8,0,0,0,0,0,0,
                         0,0,32'h00A00113,8,1,0));
        // jump after gnt, late response dropped
        tab.push_back(mk(32'hC,0,0,1,0,0,0, 1,1,N,8,0,0));
        tab.push_back(mk(32'hC,1,0,0,0,0,0, 0,1,N,8,0,0));
        tab.push_back(mk(32'h100,0,0,0,0,0,0, 0,1,N,8,0,0));
        tab.push_back(mk(32'h100,0,0,0,1,32'hDEADBEEF,0,
                         0,1,N,8,0,0));
        tab.push_back(mk(32'h100,0,0,1,0,0,0, 1,1,N,8,0,0));
        tab.push_back(mk(32'h100,0,0,0,1,32'h00000517,0,
                         0,0,32'h00000517,32'h100,1,0));
        // jump+stall flushes valid output
        tab.push_back(mk(32'h104,1,1,0,0,0,0,
                         1,1,N,32'h100,0,0));
        // gnt with jump -> DROP, jumps in DROP ignored
        tab.push_back(mk(32'h200,1,0,1,0,0,0,
                         1,1,N,32'h100,0,0));
        tab.push_back(mk(32'h300,1,0,0,0,0,0,
                         0,1,N,32'h100,0,0));
        tab.push_back(mk(32'h300,0,0,0,1,32'h55555555,0,
                         0,1,N,32'h100,0,0));
        // jump coincident with rvalid in WAIT
        tab.push_back(mk(32'h300,0,0,1,0,0,0,
                         1,1,N,32'h100,0,0));
        tab.push_back(mk(32'h300,1,0,0,1,32'h66666666,0,
                         0,1,N,32'h100,0,0));
        // jump while buffered
        tab.push_back(mk(32'h400,0,0,1,0,0,0,
                         1,1,N,32'h100,0,0));
        tab.push_back(mk(32'h400,0,1,0,1,32'h11111111,0,
                         0,1,N,32'h100,0,0));
        tab.push_back(mk(32'h400,1,1,0,0,0,0,
                         0,1,N,32'h100,0,0));
        // idle WAIT cycle, then deliver, then stall holds it
        tab.push_back(mk(32'h500,0,0,1,0,0,0,
                         1,1,N,32'h100,0,0));
        tab.push_back(mk(32'h500,0,0,0,0,0,0,
                         0,1,N,32'h100,0,0));
        tab.push_back(mk(32'h500,0,0,0,1,32'h22222222,0,
                         0,0,32'h22222222,32'h500,1,0));
        tab.push_back(mk(32'h504,0,1,0,0,0,0,
                         1,1,32'h22222222,32'h500,1,0));
        tab.push_back(mk(32'h504,0,0,1,0,0,0,
                         1,1,N,32'h500,0,0));

        // after mid-transaction reset: stale rvalid in IDLE/REQ ignored
        seq.push_back(mk(0,0,0,0,1,32'h33333333,0, 0,1,N,0,0,0));
        seq.push_back(mk(0,0,0,0,1,32'h33333333,0, 1,1,N,0,0,0));
        seq.push_back(mk(0,0,0,1,0,0,0, 1,1,N,0,0,0));
        seq.push_back(mk(0,0,0,0,1,32'h44444444,0,
                         0,0,32'h44444444,0,1,0));
`ifdef IFETCH_BUS_ERR_EN
        seq.push_back(mk(4,0,0,1,0,0,0, 1,1,N,0,0,0));
        seq.push_back(mk(4,0,0,0,1,32'hFFFFFFFF,1, 0,0,N,4,1,1));
        seq.push_back(mk(8,0,0,1,0,0,0, 1,1,N,4,0,0));
        seq.push_back(mk(8,0,1,0,1,32'hFFFFFFFF,1, 0,1,N,4,0,0));
        seq.push_back(mk(8,0,0,0,0,0,0, 0,0,N,8,1,1));
        seq.push_back(mk(32'hC,0,0,1,0,0,0, 1,1,N,8,0,0));
        seq.push_back(mk(32'hC,0,0,0,1,32'h00C00193,0,
                         0,0,32'h00C00193,32'hC,1,0));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_reset(-1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tab[i]) run(tab[i], i);

        @(negedge clk);
        pc = 0; jump = 0; stall = 0; gnt = 0;
        rvalid = 0; rdata = 0; merr = 0;
        rst_n = 1'b0;
        #1;
        chk_reset(-2);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (seq[i]) run(seq[i], 100 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want done");
        $fatal(1, "timeout");
    end

endmodule
